// File: rtl/id_decode_stage.sv
// RV32I decode stage: register file with write-through bypass, control decode, immediates, load-use hazard.
// Combinational 0-cycle decode/read; a load-use hazard raises stall_o and bubble_o for one cycle.
module id_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   PC_i,
    input  logic [31:0]       inst_i,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_regWEn,
    input  logic [1:0]        ex_wb_sel,
    output logic [XLEN-1:0]   PC_o,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   dataR1_o,
    output logic [XLEN-1:0]   dataR2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              a_sel_o,
    output logic              b_sel_o,
    output logic              BrUn_o,
    output logic [3:0]        alu_sel_o,
    output logic              regWEn_o,
    output logic              memRW_o,
    output logic [1:0]        wb_sel_o,
    output logic [2:0]        ld_st_sel_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic            use_rs1;
    logic            use_rs2;
    logic            illegal_dec;
    logic            hazard;
    logic            illegal_q;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];

    assign PC_o   = PC_i;
    assign inst_o = inst_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // WB bypass lets a value written this cycle be read this cycle; x0 never bypasses.
    always_comb begin
        dataR1_o = '0;
        dataR2_o = '0;
        if (!reset && rs1 != 5'd0) begin
            dataR1_o = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        end
        if (!reset && rs2 != 5'd0) begin
            dataR2_o = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
        end
    end

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        a_sel_o     = 1'b0;
        b_sel_o     = 1'b0;
        BrUn_o      = 1'b0;
        alu_sel_o   = ALU_ADD;
        regWEn_o    = 1'b0;
        memRW_o     = 1'b0;
        wb_sel_o    = WB_MEM;
        ld_st_sel_o = 3'd0;
        imm_o       = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        illegal_dec = 1'b0;
        if (!reset) begin
            case (opcode)
                OP_R: begin
                    alu_sel_o = arith_op(funct3, inst_i[30], 1'b1);
                    regWEn_o  = 1'b1;
                    wb_sel_o  = WB_ALU;
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                end
                OP_I: begin
                    b_sel_o   = 1'b1;
                    alu_sel_o = arith_op(funct3, inst_i[30], 1'b0);
                    regWEn_o  = 1'b1;
                    wb_sel_o  = WB_ALU;
                    imm_o     = imm_i;
                    use_rs1   = 1'b1;
                end
                OP_LOAD: begin
                    b_sel_o     = 1'b1;
                    regWEn_o    = 1'b1;
                    wb_sel_o    = WB_MEM;
                    ld_st_sel_o = funct3;
                    imm_o       = imm_i;
                    use_rs1     = 1'b1;
                end
                OP_STORE: begin
                    b_sel_o     = 1'b1;
                    memRW_o     = 1'b1;
                    ld_st_sel_o = funct3;
                    imm_o       = imm_s;
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                end
                OP_BRANCH: begin
                    a_sel_o = 1'b1;
                    b_sel_o = 1'b1;
                    BrUn_o  = funct3[1];
                    imm_o   = imm_b;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_JAL: begin
                    a_sel_o  = 1'b1;
                    b_sel_o  = 1'b1;
                    regWEn_o = 1'b1;
                    wb_sel_o = WB_PC4;
                    imm_o    = imm_j;
                end
                OP_JALR: begin
                    b_sel_o  = 1'b1;
                    regWEn_o = 1'b1;
                    wb_sel_o = WB_PC4;
                    imm_o    = imm_i;
                    use_rs1  = 1'b1;
                end
                OP_LUI: begin
                    b_sel_o   = 1'b1;
                    alu_sel_o = ALU_PASS_B;
                    regWEn_o  = 1'b1;
                    wb_sel_o  = WB_ALU;
                    imm_o     = imm_u;
                end
                OP_AUIPC: begin
                    a_sel_o  = 1'b1;
                    b_sel_o  = 1'b1;
                    regWEn_o = 1'b1;
                    wb_sel_o = WB_ALU;
                    imm_o    = imm_u;
                end
                default: illegal_dec = 1'b1;
            endcase
        end
    end

    // The WB bypass cannot cover a load still in EX, so it stalls even when WB writes the same register.
    assign hazard = !reset && ex_regWEn && (ex_wb_sel == WB_MEM) && (ex_rd != 5'd0) &&
                    ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));

    assign stall_o  = hazard;
    assign bubble_o = hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (illegal_dec && !stall_o) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed-vector bench for id_decode_stage; expectations are queued at issue and checked by a separate monitor.
module tb_id_decode_stage;

    localparam logic [5:0] M_D1 = 6'd1, M_D2 = 6'd2, M_IMM = 6'd4, M_CTRL = 6'd8, M_HAZ = 6'd16, M_ILL = 6'd32;
    localparam logic [5:0] M_ALL = 6'h3F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC_i = '0;
    logic [31:0] inst_i = 32'h0000_0013;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_regWEn = 1'b0;
    logic [1:0]  ex_wb_sel = 2'd1;
    logic [31:0] PC_o, inst_o, dataR1_o, dataR2_o, imm_o;
    logic        a_sel_o, b_sel_o, BrUn_o, regWEn_o, memRW_o, stall_o, bubble_o, illegal_o;
    logic [3:0]  alu_sel_o;
    logic [1:0]  wb_sel_o;
    logic [2:0]  ld_st_sel_o;

    id_decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .PC_i(PC_i), .inst_i(inst_i),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_rd(ex_rd), .ex_regWEn(ex_regWEn), .ex_wb_sel(ex_wb_sel),
        .PC_o(PC_o), .inst_o(inst_o), .dataR1_o(dataR1_o), .dataR2_o(dataR2_o), .imm_o(imm_o),
        .a_sel_o(a_sel_o), .b_sel_o(b_sel_o), .BrUn_o(BrUn_o), .alu_sel_o(alu_sel_o),
        .regWEn_o(regWEn_o), .memRW_o(memRW_o), .wb_sel_o(wb_sel_o), .ld_st_sel_o(ld_st_sel_o),
        .stall_o(stall_o), .bubble_o(bubble_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reset;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  ex_rd;
        logic        ex_regWEn;
        logic [1:0]  ex_wb_sel;
    } drv_t;

    typedef struct {
        string       name;
        logic [5:0]  m;
        logic [31:0] pc, ins, d1, d2, imm;
        logic [13:0] ctrl;
        logic [1:0]  haz;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t me;
    drv_t nd;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    // {a_sel, b_sel, BrUn, alu_sel[3:0], regWEn, memRW, wb_sel[1:0], ld_st_sel[2:0]}
    function automatic logic [13:0] C(input logic a, input logic b, input logic u, input logic [3:0] alu,
                                      input logic rw, input logic mw, input logic [1:0] wb, input logic [2:0] ls);
        return {a, b, u, alu, rw, mw, wb, ls};
    endfunction

    function automatic drv_t idle();
        drv_t d;
        d.reset = 1'b0; d.wb_en = 1'b0; d.wb_rd = '0; d.wb_data = '0;
        d.ex_rd = '0; d.ex_regWEn = 1'b0; d.ex_wb_sel = 2'd1;
        return d;
    endfunction

    task automatic vec(input string nm, input logic [31:0] ins, input logic [5:0] m,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                       input logic [13:0] c, input logic [1:0] hz, input logic il);
        exp_t e;
        @(posedge clk);
        #1;
        reset = nd.reset; wb_en = nd.wb_en; wb_rd = nd.wb_rd; wb_data = nd.wb_data;
        ex_rd = nd.ex_rd; ex_regWEn = nd.ex_regWEn; ex_wb_sel = nd.ex_wb_sel;
        inst_i = ins;
        pc_ctr = pc_ctr + 32'd4;
        PC_i = pc_ctr;
        e.name = nm; e.m = m; e.pc = pc_ctr; e.ins = ins; e.d1 = d1; e.d2 = d2; e.imm = im;
        e.ctrl = c; e.haz = hz; e.ill = il;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s.%s got %h want %h", nm, fld, act, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                me = q.pop_front();
                chk(me.name, "pc", PC_o, me.pc);
                chk(me.name, "inst", inst_o, me.ins);
                if (me.m[0]) chk(me.name, "dataR1", dataR1_o, me.d1);
                if (me.m[1]) chk(me.name, "dataR2", dataR2_o, me.d2);
                if (me.m[2]) chk(me.name, "imm", imm_o, me.imm);
                if (me.m[3]) chk(me.name, "ctrl", 32'({a_sel_o, b_sel_o, BrUn_o, alu_sel_o, regWEn_o,
                                                        memRW_o, wb_sel_o, ld_st_sel_o}), 32'(me.ctrl));
                if (me.m[4]) chk(me.name, "stall_bubble", 32'({stall_o, bubble_o}), 32'(me.haz));
                if (me.m[5]) chk(me.name, "illegal", 32'(illegal_o), 32'(me.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    localparam logic [13:0] C_R    = 14'({1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 3'd0});
    localparam logic [13:0] C_ADDI = 14'({1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 3'd0});

    initial begin
        // Reset with a hazard pattern and a WB write pending: everything must read as quiet.
        nd = idle();
        nd.reset = 1'b1; nd.wb_en = 1'b1; nd.wb_rd = 5'd3; nd.wb_data = 32'h55;
        nd.ex_regWEn = 1'b1; nd.ex_wb_sel = 2'd0; nd.ex_rd = 5'd3;
        vec("reset", 32'h0011_8233, M_D1 | M_D2 | M_CTRL | M_HAZ | M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b0);

        nd = idle();
        for (int i = 0; i < 32; i++) begin
            vec($sformatf("rd_all_x%0d", i), (32'(31 - i) << 20) | (32'(i) << 15) | 32'h33,
                M_D1 | M_D2 | M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        end

        nd.wb_en = 1'b1; nd.wb_rd = 5'd5; nd.wb_data = 32'hDEAD_BEEF;
        vec("bypass_x5", 32'h0002_8333, M_ALL, 32'hDEAD_BEEF, 0, 0, C_R, 2'b00, 1'b0);
        nd = idle();
        vec("file_x5", 32'h0002_8333, M_D1 | M_D2, 32'hDEAD_BEEF, 0, 0, 14'd0, 2'b00, 1'b0);
        nd.wb_en = 1'b1; nd.wb_rd = 5'd0; nd.wb_data = 32'h1234;
        vec("wr_x0", 32'h0050_0333, M_D1 | M_D2, 0, 32'hDEAD_BEEF, 0, 14'd0, 2'b00, 1'b0);
        nd = idle();
        vec("rd_x0", 32'h0050_0333, M_D1 | M_D2, 0, 32'hDEAD_BEEF, 0, 14'd0, 2'b00, 1'b0);

        nd.wb_en = 1'b1; nd.wb_rd = 5'd1; nd.wb_data = 32'h100;
        vec("nop", 32'h0000_0013, M_D1 | M_IMM | M_CTRL | M_HAZ, 0, 0, 0, C_ADDI, 2'b00, 1'b0);
        nd.wb_rd = 5'd2; nd.wb_data = 32'h200;
        vec("sw", 32'hFE20_AE23, M_ALL, 32'h100, 32'h200, 32'hFFFF_FFFC,
            C(0, 1, 0, 4'd0, 0, 1, 2'd0, 3'd2), 2'b00, 1'b0);
        nd = idle();
        vec("bltu", 32'h0020_E463, M_ALL, 32'h100, 32'h200, 32'd8, C(1, 1, 1, 4'd0, 0, 0, 2'd0, 3'd0), 2'b00, 1'b0);
        vec("beq_neg", 32'hFE00_0EE3, M_IMM | M_CTRL, 0, 0, 32'hFFFF_FFFC, C(1, 1, 0, 4'd0, 0, 0, 2'd0, 3'd0), 2'b00, 1'b0);
        vec("lui", 32'hABCD_E0B7, M_IMM | M_CTRL, 0, 0, 32'hABCD_E000, C(0, 1, 0, 4'd10, 1, 0, 2'd1, 3'd0), 2'b00, 1'b0);
        vec("jal", 32'h0100_00EF, M_IMM | M_CTRL, 0, 0, 32'd16, C(1, 1, 0, 4'd0, 1, 0, 2'd2, 3'd0), 2'b00, 1'b0);
        vec("jal_neg", 32'hFFFF_F06F, M_IMM | M_CTRL, 0, 0, 32'hFFFF_FFFE, C(1, 1, 0, 4'd0, 1, 0, 2'd2, 3'd0), 2'b00, 1'b0);
        vec("jalr", 32'h0041_00E7, M_D1 | M_IMM | M_CTRL, 32'h200, 0, 32'd4, C(0, 1, 0, 4'd0, 1, 0, 2'd2, 3'd0), 2'b00, 1'b0);
        vec("srai", 32'h4030_D393, M_D1 | M_IMM | M_CTRL, 32'h100, 0, 32'h403, C(0, 1, 0, 4'd7, 1, 0, 2'd1, 3'd0), 2'b00, 1'b0);
        vec("sub", 32'h4020_8433, M_ALL, 32'h100, 32'h200, 0, C(0, 0, 0, 4'd1, 1, 0, 2'd1, 3'd0), 2'b00, 1'b0);
        vec("srl", 32'h0020_D433, M_CTRL, 0, 0, 0, C(0, 0, 0, 4'd6, 1, 0, 2'd1, 3'd0), 2'b00, 1'b0);
        vec("addi_neg", 32'hC000_8093, M_IMM | M_CTRL, 0, 0, 32'hFFFF_FC00, C_ADDI, 2'b00, 1'b0);
        vec("lw", 32'h0080_A183, M_IMM | M_CTRL, 0, 0, 32'd8, C(0, 1, 0, 4'd0, 1, 0, 2'd0, 3'd2), 2'b00, 1'b0);
        vec("auipc", 32'h0000_1297, M_IMM | M_CTRL, 0, 0, 32'h1000, C(1, 1, 0, 4'd0, 1, 0, 2'd1, 3'd0), 2'b00, 1'b0);

        // EX holds lw x3 unless noted.
        nd.ex_regWEn = 1'b1; nd.ex_wb_sel = 2'd0; nd.ex_rd = 5'd3;
        vec("haz_rs1", 32'h0011_8233, M_CTRL | M_HAZ, 0, 0, 0, C_R, 2'b11, 1'b0);
        nd.ex_regWEn = 1'b0;
        vec("haz_clear", 32'h0011_8233, M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        nd.ex_regWEn = 1'b1;
        vec("haz_rs2", 32'h0030_8233, M_HAZ, 0, 0, 0, 14'd0, 2'b11, 1'b0);
        vec("haz_lui", 32'h0001_81B7, M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        vec("haz_addi_rs2f", 32'h0030_8213, M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        vec("haz_sw_rs2", 32'h0030_A023, M_HAZ, 0, 0, 0, 14'd0, 2'b11, 1'b0);
        nd.ex_wb_sel = 2'd1;
        vec("haz_alu_ex", 32'h0011_8233, M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        nd.ex_wb_sel = 2'd0; nd.ex_rd = 5'd0;
        vec("haz_exrd0", 32'h0010_0233, M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        nd.ex_rd = 5'd3; nd.wb_en = 1'b1; nd.wb_rd = 5'd3; nd.wb_data = 32'h333;
        vec("haz_wb_same", 32'h0011_8233, M_D1 | M_HAZ, 32'h333, 0, 0, 14'd0, 2'b11, 1'b0);
        nd.wb_en = 1'b0; nd.reset = 1'b1;
        vec("haz_reset", 32'h0011_8233, M_D1 | M_CTRL | M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        nd = idle();
        vec("post_rst_x3", 32'h0011_8233, M_D1 | M_D2 | M_HAZ, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        vec("post_rst_x5", 32'h0002_8333, M_D1, 0, 0, 0, 14'd0, 2'b00, 1'b0);

        vec("ill_dec", 32'h0000_0000, M_CTRL | M_HAZ | M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b0);
        vec("ill_set", 32'h0000_0013, M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b1);
        vec("ill_hold", 32'h0000_0013, M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b1);
        nd.reset = 1'b1;
        vec("ill_in_rst", 32'h0000_0013, M_CTRL | M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b1);
        nd = idle();
        vec("ill_cleared", 32'h0000_0013, M_ILL, 0, 0, 0, 14'd0, 2'b00, 1'b0);

        @(negedge clk);
        #1;
        chk("drain", "queue_left", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
